// File: rtl/tb_ctrl_periph.sv
// Testbench control peripheral: stdout FIFO, pass/fail/exit flags, compare timer.
// Latency: grant is combinational; response and all register effects appear one cycle after the grant.
// Backpressure: a PUTC byte write is held off (gnt_o low) while the FIFO is full; the sink pops with char_ready_i.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i bus request side (64-byte window, word offset addr_i[5:2])
//   rvalid_o/rdata_o                    registered response, one cycle after each grant
//   char_valid_o/char_o/char_ready_i    stdout byte stream from the FIFO head
//   tests_passed_o/tests_failed_o       sticky result flags
//   exit_valid_o/exit_value_o           sticky exit request and code
//   timer_irq_o                         timer pending, level
module tb_ctrl_periph #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter logic [31:0] PASS_MAGIC = 32'd123456789,
   parameter logic [31:0] FAIL_MAGIC = 32'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        char_valid_o,
   output logic [7:0]  char_o,
   input  logic        char_ready_i,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o,
   output logic        timer_irq_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [3:0] OFF_PUTC   = 4'd0;
   localparam logic [3:0] OFF_EXIT   = 4'd1;
   localparam logic [3:0] OFF_STATUS = 4'd2;
   localparam logic [3:0] OFF_TCNT   = 4'd3;
   localparam logic [3:0] OFF_TCMP   = 4'd4;
   localparam logic [3:0] OFF_TCTRL  = 4'd5;

   logic [3:0]  off;
   logic        wr;
   logic        rd;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] level;
   logic [7:0]  mem [FIFO_DEPTH];

   logic [31:0] tcnt;
   logic [31:0] tcmp;
   logic        tmr_en;
   logic        pending;
   logic        match;
   logic [31:0] rd_mux;

   // Only the word offset is decoded; the router already qualified the window.
   logic unused_addr;
   assign unused_addr = ^{addr_i[31:6], addr_i[1:0]};

   assign off = addr_i[5:2];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign level = wr_ptr - rd_ptr;

   assign gnt_o = req_i & ~(we_i & (off == OFF_PUTC) & be_i[0] & full);
   assign wr    = gnt_o & we_i;
   assign rd    = gnt_o & ~we_i;
   assign push  = wr & (off == OFF_PUTC) & be_i[0];
   assign pop   = char_valid_o & char_ready_i;

   assign char_valid_o = ~empty;
   // Gated so the head reads 0 when empty, including straight out of reset.
   assign char_o       = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata_i[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   function automatic logic [31:0] be_merge(input logic [31:0] cur, input logic [31:0] nxt,
                                            input logic [3:0] be);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = nxt[8*b +: 8];
      end
      return res;
   endfunction

   assign match = tmr_en && (tcnt == tcmp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exit_valid_o   <= 1'b0;
         exit_value_o   <= '0;
         tests_passed_o <= 1'b0;
         tests_failed_o <= 1'b0;
         tcnt           <= '0;
         tcmp           <= 32'hFFFF_FFFF;
         tmr_en         <= 1'b0;
         pending        <= 1'b0;
      end else begin
         if (wr && off == OFF_EXIT) begin
            exit_valid_o <= 1'b1;
            exit_value_o <= be_merge(exit_value_o, wdata_i, be_i);
         end
         if (wr && off == OFF_STATUS) begin
            if (wdata_i == PASS_MAGIC) tests_passed_o <= 1'b1;
            if (wdata_i == FAIL_MAGIC) tests_failed_o <= 1'b1;
         end
         // A bus write overrides the increment in the same cycle.
         if (wr && off == OFF_TCNT)  tcnt <= be_merge(tcnt, wdata_i, be_i);
         else if (tmr_en)            tcnt <= tcnt + 32'd1;
         if (wr && off == OFF_TCMP)  tcmp <= be_merge(tcmp, wdata_i, be_i);
         if (wr && off == OFF_TCTRL && be_i[0]) tmr_en <= wdata_i[0];
         // Set has priority over write-1-clear so a coincident match is not lost.
         if (match)
            pending <= 1'b1;
         else if (wr && off == OFF_TCTRL && be_i[0] && wdata_i[1])
            pending <= 1'b0;
      end
   end

   assign timer_irq_o = pending;

   always_comb begin
      rd_mux = '0;
      case (off)
         OFF_PUTC:   rd_mux = {{(31-AW){1'b0}}, level};
         OFF_EXIT:   rd_mux = exit_value_o;
         OFF_STATUS: rd_mux = {30'b0, tests_failed_o, tests_passed_o};
         OFF_TCNT:   rd_mux = tcnt;
         OFF_TCMP:   rd_mux = tcmp;
         OFF_TCTRL:  rd_mux = {30'b0, pending, tmr_en};
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
      end else begin
         rvalid_o <= gnt_o;
         rdata_o  <= rd ? rd_mux : 32'h0;
      end
   end

endmodule

// File: doc/tb_ctrl_periph.md
# tb_ctrl_periph

Memory-mapped testbench control peripheral on the core's data bus inside the testbench subsystem, one stage upstream of the testbench top. It turns core stores into stdout characters via a small FIFO, drives the pass/fail/exit result signals the top watches, and provides a compare timer with interrupt. The data-port router asserts `req_i` only for addresses inside this block's 64-byte window.

## Interface
- `FIFO_DEPTH`, 16: stdout character FIFO entries, power of two, at least 2.
- `PASS_MAGIC`, 32'd123456789: STATUS write value that sets pass.
- `FAIL_MAGIC`, 32'd1: STATUS write value that sets fail.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  bus request, already decoded to this window.
- `gnt_o`  out  1  request accepted this cycle.
- `addr_i`  in  32  byte address; only bits [5:2] are used.
- `we_i`  in  1  1 = write.
- `be_i`  in  4  byte enables.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid.
- `rdata_o`  out  32  read data; 0 on write responses.
- `char_valid_o`  out  1  FIFO not empty.
- `char_o`  out  8  FIFO head byte.
- `char_ready_i`  in  1  sink pops the head when high together with `char_valid_o`.
- `tests_passed_o`  out  1  sticky pass.
- `tests_failed_o`  out  1  sticky fail.
- `exit_valid_o`  out  1  sticky exit request.
- `exit_value_o`  out  32  exit code.
- `timer_irq_o`  out  1  timer interrupt, level.

## Operation
Register map by word offset `addr_i[5:2]`:
- 0 PUTC
  - W: push `wdata_i[7:0]` when `be_i[0]` is set.
  - R: FIFO level in `[$clog2(FIFO_DEPTH):0]`.
- 1 EXIT
  - W: `exit_value_o` takes `wdata_i` and `exit_valid_o` goes to 1.
  - R: `exit_value_o`.
- 2 STATUS
  - W: `PASS_MAGIC` sets pass; `FAIL_MAGIC` sets fail; any other value is ignored.
  - R: {30'b0, fail, pass}.
- 3 TCNT: R/W, 32-bit counter.
- 4 TCMP: R/W, compare value. Reset value is 32'hFFFF_FFFF.
- 5 TCTRL
  - Bit 0: enable (R/W).
  - Bit 1: pending. Reads return it; writing 1 clears it.
- Offsets 6 to 15: reads return 0, writes are ignored, and the access is still granted.

Register rules:
- TCNT, TCMP and EXIT writes honour `be_i` per byte.
- TCTRL bit 0 is updated only when `be_i[0]` is set.
- TCTRL bit 1 clear also requires `be_i[0]`.
- Pass, fail and exit are sticky until reset. Pass and fail may both be set.

Timer:
- When enabled, TCNT increments every cycle and wraps from 32'hFFFF_FFFF to 0.
- When TCNT == TCMP while enabled, pending is set.
- `timer_irq_o` = pending.
- A bus write to TCNT in the same cycle as an increment: the written value wins.
- Pending set and write-1-clear in the same cycle: set wins.

FIFO:
- Circular buffer with read/write pointers that are one bit wider than the index.
- It is full when the indices are equal and the MSBs differ.
- A push and a pop in the same cycle keep the level unchanged.
- A push when full cannot happen, because the grant is withheld.

## Timing
- Grant rule: `gnt_o` = `req_i` & !(`we_i` & PUTC & `be_i[0]` & full). This is combinational. The master holds the request until it is granted.
- A granted access takes effect at the granting clock edge.
- `rvalid_o` is 1 in the cycle after each grant. `rdata_o` is registered and reflects register state before that edge's write.
- Back-to-back grants give back-to-back `rvalid_o`, one per cycle.
- A PUTC push is visible on `char_valid_o`/`char_o` the cycle after the grant.
- The FIFO level updates the cycle after a pop.
- Timer pending is set the cycle after the matching count value. `timer_irq_o` is registered.
- Reset values:
  - `gnt_o` = 0 when `req_i` = 0.
  - `rvalid_o`, `rdata_o`, `char_valid_o`, `char_o` = 0.
  - `tests_passed_o`, `tests_failed_o`, `exit_valid_o`, `exit_value_o` = 0.
  - `timer_irq_o` = 0.
  - FIFO empty, TCNT = 0, timer disabled.
- Reset mid-access drops any pending `rvalid_o` and flushes the FIFO.

## Test plan
- STATUS write of 123456789 → next cycle `rvalid_o`=1 and `tests_passed_o`=1. A later write of 5 changes nothing. A write of 1 then also sets `tests_failed_o`.
- EXIT write of 32'h0000_0007 with `be_i`=4'b0001 → `exit_valid_o`=1 and `exit_value_o`=7. A read of EXIT returns 7.
- With `char_ready_i`=0, push 17 bytes at `FIFO_DEPTH`=16 → the 17th request stalls (`gnt_o`=0) and PUTC reads 16. Raise `char_ready_i` → bytes drain in order and the 17th is granted one cycle after the first pop.
- Simultaneous push and pop at level 3 → level stays 3 and ordering is preserved.
- TCMP=10, TCNT=0, enable → `timer_irq_o` rises on the cycle after TCNT reaches 10. A write-1-clear in the same cycle as a match leaves pending set.
- Assert `rst_n` low while PUTC holds 5 bytes and a read is outstanding → all outputs return to 0 asynchronously and no `rvalid_o` follows release.
